// File: rtl/result_writeback.sv
// Result writeback stage for the CORDIC pipeline.
// Captures final x/y/z results into a 100-bit packet for the processor.
// tan/tanh need a second division pass: x/y are held as divisor/dividend,
// and the pass is launched with a one-cycle chain_load pulse. When the
// second done arrives, the packet is built from the held x/y plus the new z.
module result_writeback (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  x_result,
    input  logic [31:0]  y_result,
    input  logic [31:0]  z_result,
    input  logic         done,
    input  logic [3:0]   opcode,
    input  logic         out_ready,
    output logic [99:0]  result_packet,
    output logic         result_valid,
    output logic         stall,
    output logic         chain_load,
    output logic [31:0]  chain_x,
    output logic [31:0]  chain_y,
    output logic         overrun
);

    localparam logic [3:0] OP_TAN  = 4'd7;
    localparam logic [3:0] OP_TANH = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        CHAIN_REQ,
        CHAIN_WAIT,
        OUTPUT
    } state_t;

    state_t     state;
    logic [3:0] op_q;

    // Writeback FSM; every output is registered and updated with the state.
    // chain_load is raised on entry to CHAIN_REQ so it is high exactly while
    // in that state, and it drops by default on every other cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            op_q          <= '0;
            result_packet <= '0;
            result_valid  <= 1'b0;
            stall         <= 1'b0;
            chain_load    <= 1'b0;
            chain_x       <= '0;
            chain_y       <= '0;
            overrun       <= 1'b0;
        end else begin
            chain_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (done) begin
                        stall <= 1'b1;
                        if (opcode == OP_TAN || opcode == OP_TANH) begin
                            op_q       <= opcode;
                            chain_x    <= x_result;
                            chain_y    <= y_result;
                            chain_load <= 1'b1;
                            state      <= CHAIN_REQ;
                        end else begin
                            result_packet <= {opcode, z_result, y_result, x_result};
                            result_valid  <= 1'b1;
                            state         <= OUTPUT;
                        end
                    end
                end
                CHAIN_REQ: begin
                    // A done here cannot belong to the chained pass yet.
                    if (done) begin
                        overrun <= 1'b1;
                    end
                    state <= CHAIN_WAIT;
                end
                CHAIN_WAIT: begin
                    if (done) begin
                        result_packet <= {op_q, z_result, chain_y, chain_x};
                        result_valid  <= 1'b1;
                        state         <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    // Packet is held; a new result is dropped and flagged.
                    if (done) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        result_valid <= 1'b0;
                        stall        <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    stall        <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset sampled on the clock's rising edge.
REQ-003 SHALL have port x_result, input, 32, CORDIC final x (IEEE-754 single).
REQ-004 SHALL have port y_result, input, 32, CORDIC final y.
REQ-005 SHALL have port z_result, input, 32, CORDIC final z.
REQ-006 SHALL have port done, input, 1, one-cycle pulse: x/y/z_result are valid this cycle.
REQ-007 SHALL have port opcode, input, 4, opcode of the operation in flight (0..10 as in the Fetch opcode table).
REQ-008 SHALL have port out_ready, input, 1, processor accepts result_packet this cycle.
REQ-009 SHALL have port result_packet, output, 100, packet {opcode[3:0], z[31:0], y[31:0], x[31:0]}.
REQ-010 SHALL have port result_valid, output, 1, result_packet holds a valid result.
REQ-011 SHALL have port stall, output, 1, drives Fetch stall; high in every state except IDLE.
REQ-012 SHALL have port chain_load, output, 1, one-cycle pulse that launches the chained division pass.
REQ-013 SHALL have port chain_x, output, 32, divisor for the chained pass.
REQ-014 SHALL have port chain_y, output, 32, dividend for the chained pass.
REQ-015 SHALL have port overrun, output, 1, sticky flag: done arrived while not accepting.

Function
REQ-016 SHALL implement FSM states IDLE, CHAIN_REQ, CHAIN_WAIT, OUTPUT.
REQ-017 SHALL, in IDLE with done=1 and opcode in {7 tan, 8 tanh}, latch opcode, chain_x<=x_result, chain_y<=y_result, and go to CHAIN_REQ.
REQ-018 SHALL, in IDLE with done=1 and any other opcode (0..6, 9..15), latch {opcode,z,y,x} into result_packet and go to OUTPUT next cycle.
REQ-019 SHALL, in CHAIN_REQ, assert chain_load for exactly one cycle and go to CHAIN_WAIT.
REQ-020 SHALL, in CHAIN_WAIT with done=1, latch {latched opcode, z_result, chain_y, chain_x} into result_packet and go to OUTPUT; the incoming opcode is ignored there.
REQ-021 SHALL hold chain_x/chain_y stable from capture until the next capture.
REQ-022 SHALL assert result_valid exactly while in OUTPUT; result_packet SHALL remain constant while result_valid=1.
REQ-023 SHALL, in OUTPUT with out_ready=1, return to IDLE next cycle; result_valid falls that cycle.
REQ-024 SHALL, in OUTPUT with out_ready=0, remain in OUTPUT indefinitely.
REQ-025 SHALL set overrun when done=1 in CHAIN_REQ or OUTPUT; the result is discarded and state and packet are unchanged.
REQ-026 SHALL clear overrun only by reset.
REQ-027 SHALL ignore done=1 in CHAIN_WAIT only if it coincides with chain_load. That cannot occur, because chain_load and CHAIN_WAIT are mutually exclusive.
REQ-028 SHALL ignore out_ready outside OUTPUT.
REQ-029 SHALL give a latency of 1 cycle from done (IDLE) to result_valid=1, and 3 cycles plus the division pass duration for tan/tanh.

Reset
REQ-030 SHALL, when reset=0 at a clock edge, force state IDLE, result_packet=0, result_valid=0, stall=0, chain_load=0, chain_x=0, chain_y=0, overrun=0.
REQ-031 SHALL let reset override every other input in the same cycle, including mid-chain and mid-output, with no packet emitted afterwards.

Verification
REQ-032 SHALL cover: done with opcode=0, x=3F5A9A0D, y=3EF57744, z=3F000000, out_ready=1 -> next cycle result_valid=1, packet={0,3F000000,3EF57744,3F5A9A0D}; IDLE one cycle later.
REQ-033 SHALL cover: done with opcode=7, x=3F5A9A0D, y=3EF57744 -> chain_load pulses one cycle later with chain_x=3F5A9A0D, chain_y=3EF57744, and stall=1 throughout; a second done with z=3F0BDA7B -> packet={7,3F0BDA7B,3EF57744,3F5A9A0D}, result_valid=1.
REQ-034 SHALL cover: result held with out_ready=0 for 10 cycles -> packet constant, result_valid=1, stall=1; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: done pulsed while in OUTPUT -> overrun=1 and packet unchanged; overrun stays 1 until reset=0.
REQ-036 SHALL cover: reset=0 asserted in CHAIN_WAIT -> all outputs 0 next cycle; a subsequent done with opcode=6 is processed normally.
